// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Simplez CPU bus.
// Two registers: a status word (overrun, ready) and the transmit data byte.
module simplez_uart_tx #(
    parameter int unsigned BAUD_DIV    = 104,
    parameter logic [8:0]  ADDR_STATUS = 9'h1FE,
    parameter logic [8:0]  ADDR_DATA   = 9'h1FF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [8:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [11:0] data_in,
    output logic [11:0] data_out,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned      BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        data_reg, data_next;
    logic              ovr_reg, ovr_next;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;

    logic sel_status;
    logic sel_data;
    logic bit_end;
    logic wr_data;
    logic accept;

    assign sel_status = (addr == ADDR_STATUS);
    assign sel_data   = (addr == ADDR_DATA);
    assign hit        = sel_status | sel_data;
    assign tx         = tx_reg;
    assign busy       = busy_reg;

    // Bus read path is purely combinational so the CPU sees it in the same cycle.
    always_comb begin
        data_out = 12'hFFF;
        if (rd && sel_status) begin
            data_out = {10'b0, ovr_reg, ~busy_reg};
        end else if (rd && sel_data) begin
            data_out = {4'b0, data_reg};
        end
    end

    assign bit_end = (baud_cnt_reg == BAUD_LAST);
    assign wr_data = wr && sel_data;
    // The last STOP cycle counts as free, so a write there chains frames seamlessly.
    assign accept  = wr_data && ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + BAUD_W'(1);
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        data_next     = data_reg;
        ovr_next      = ovr_reg;
        tx_next       = 1'b1;
        busy_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_reg == 3'd7) begin
                        state_next   = STOP;
                        bit_cnt_next = 3'd0;
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            state_next    = START;
            baud_cnt_next = '0;
            bit_cnt_next  = 3'd0;
            shift_next    = data_in[7:0];
            data_next     = data_in[7:0];
        end

        // A rejected write outranks the read-to-clear on the same edge.
        if (wr_data && !accept) begin
            ovr_next = 1'b1;
        end else if (rd && sel_status) begin
            ovr_next = 1'b0;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(negedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            data_reg     <= 8'h00;
            ovr_reg      <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            ovr_reg      <= ovr_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

endmodule

// File: doc/simplez_uart_tx.md
SIMPLEZ_UART_TX -- requirements
Module: simplez_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 104, clk cycles per serial bit (12 MHz / 115200); legal range 2..4095.
REQ-002 Parameter ADDR_STATUS, default 9'h1FE, status register address.
REQ-003 Parameter ADDR_DATA, default 9'h1FF, transmit data register address.
REQ-004 clk  input  1  system clock; all state updates on the falling edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 addr  input  9  CPU address bus.
REQ-007 rd  input  1  CPU read strobe (lec).
REQ-008 wr  input  1  CPU write strobe (esc).
REQ-009 data_in  input  12  CPU data bus, write value.
REQ-010 data_out  output  12  read value returned to the CPU data bus.
REQ-011 hit  output  1  high when addr equals ADDR_STATUS or ADDR_DATA; the CPU uses it for bus muxing.
REQ-012 tx  output  1  serial line, idle high.
REQ-013 busy  output  1  high while a frame is in progress.

Function
REQ-014 hit, data_out: combinational from addr and rd; no clock latency.
REQ-015 data_out = {10'b0, ovr, ready} when rd=1 and addr=ADDR_STATUS; ready = ~busy.
REQ-016 data_out = {4'b0, last byte written} when rd=1 and addr=ADDR_DATA.
REQ-017 data_out = 12'hFFF in all other cases, matching the undriven-bus value.
REQ-018 Writing ADDR_DATA while idle (wr=1) latches data_in[7:0] into the shift register and sets busy on the same edge; data_in[11:8] are ignored.
REQ-019 Writing ADDR_DATA while busy: data ignored, frame unaffected, ovr set to 1.
REQ-020 ovr clears on the edge where rd=1 and addr=ADDR_STATUS; a simultaneous set (wr) takes priority over the clear.
REQ-021 Writes to ADDR_STATUS have no effect.
REQ-022 FSM states: IDLE, START, DATA, STOP. Transitions: IDLE->START on accepted write; START->DATA after BAUD_DIV cycles; DATA->STOP after 8 bit periods; STOP->IDLE after BAUD_DIV cycles.
REQ-023 tx drives 1 in IDLE, 0 in START, shift register bit 0 in DATA (LSB first, shift right each bit period), and 1 in STOP.
REQ-024 tx falls on the edge that accepts the write; the frame lasts exactly 10*BAUD_DIV cycles.
REQ-025 busy deasserts on the edge that ends STOP.
REQ-026 A write accepted on that same edge starts a new frame with no idle gap.
REQ-027 Baud counter: ceil(log2(BAUD_DIV)) bits; reloads to 0 at each bit boundary; never wraps mid-bit.
REQ-028 Bit counter: 3 bits; DATA exits when it reaches 7 at a bit boundary.
REQ-029 rd and wr asserted together on ADDR_DATA: the write is processed as above; data_out still returns the current data register.

Reset
REQ-030 When rstn=0 on a falling clk edge: state=IDLE, tx=1, busy=0, ovr=0, data register=8'h00, baud counter=0, bit counter=0.
REQ-031 Reset applied mid-frame aborts the frame immediately; tx=1 from that edge on, with no partial stop bit.
REQ-032 Outputs are defined from the first edge with rstn=0; no dependence on power-up initial values.

Verification
REQ-033 BAUD_DIV=4; write 12'hA55 to 9'h1FF -> tx sequence over 40 cycles, 4 cycles each: 0,1,0,1,0,1,0,1,0,1; busy high for exactly 40 cycles.
REQ-034 Read 9'h1FE while idle -> data_out=12'h001; read 9'h1FE during a frame -> 12'h000; read 9'h100 -> 12'hFFF with hit=0.
REQ-035 Second write 12'h0FF issued 5 cycles into a frame -> tx stream unchanged from the first byte; status read returns 12'h002; the next status read, after frame end, returns 12'h001.
REQ-036 Write accepted on the exact edge the STOP bit ends -> tx goes low on that edge; busy never drops.
REQ-037 rstn=0 for one edge at cycle 13 of a frame -> tx=1 and busy=0 from that edge; a later write of 12'h0C3 produces a correct full frame.
REQ-038 Write 12'h3C0 then read 9'h1FF -> data_out=12'h0C0.
